// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the ALU
// result path (source 0) and the multi-cycle/load result path (source 1).
module rf_write_arbiter #(
   parameter int N = 8,
   parameter int A = 3,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         freeze,
   input  logic         req0_valid,
   input  logic [A-1:0] req0_addr,
   input  logic [N-1:0] req0_data,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [A-1:0] req1_addr,
   input  logic [N-1:0] req1_data,
   output logic         req1_ready,
   output logic         wr_en,
   output logic [A-1:0] wr_addr,
   output logic [N-1:0] wr_data,
   output logic         last_grant,
   output logic [W-1:0] wr_count
);

   logic         r_ptr;
   logic         r_wr_en;
   logic [A-1:0] r_wr_addr;
   logic [N-1:0] r_wr_data;
   logic         r_last_grant;
   logic [W-1:0] r_wr_count;

   logic         w_gnt0;
   logic         w_gnt1;
   logic         w_any;
   logic [A-1:0] w_addr;
   logic [N-1:0] w_data;

   // Register 0 is hardwired zero, so writes to it are accepted but dropped.
   function automatic logic f_addr_writable(input logic [A-1:0] addr);
      return (addr != {A{1'b0}});
   endfunction

   // Grant decode: pointer only matters when both sources are valid.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (n_reset && !freeze) begin
         w_gnt0 = req0_valid && (!req1_valid || !r_ptr);
         w_gnt1 = req1_valid && (!req0_valid ||  r_ptr);
      end else begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end
      w_any = w_gnt0 | w_gnt1;
      if (w_gnt1) begin
         w_addr = req1_addr;
         w_data = req1_data;
      end else begin
         w_addr = req0_addr;
         w_data = req0_data;
      end
   end

   // Registered write port, pointer rotation and committed-write counter.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_ptr        <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= {A{1'b0}};
         r_wr_data    <= {N{1'b0}};
         r_last_grant <= 1'b0;
         r_wr_count   <= {W{1'b0}};
      end else if (w_any) begin
         r_ptr        <= w_gnt0;
         r_last_grant <= w_gnt1;
         r_wr_en      <= f_addr_writable(w_addr);
         r_wr_addr    <= w_addr;
         r_wr_data    <= w_data;
         if (f_addr_writable(w_addr)) begin
            r_wr_count <= r_wr_count + {{(W-1){1'b0}}, 1'b1};
         end else begin
            r_wr_count <= r_wr_count;
         end
      end else begin
         r_wr_en      <= 1'b0;
      end
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign last_grant = r_last_grant;
   assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, reset corner cases and
// randomized traffic against a behavioural round-robin model.
module tb_rf_write_arbiter;
   localparam int N = 8;
   localparam int A = 3;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         n_reset = 1'b0;
   logic         freeze = 1'b0;
   logic         req0_valid = 1'b0;
   logic [A-1:0] req0_addr = '0;
   logic [N-1:0] req0_data = '0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [A-1:0] req1_addr = '0;
   logic [N-1:0] req1_data = '0;
   logic         req1_ready;
   logic         wr_en;
   logic [A-1:0] wr_addr;
   logic [N-1:0] wr_data;
   logic         last_grant;
   logic [W-1:0] wr_count;

   rf_write_arbiter #(.N(N), .A(A), .W(W)) dut (
      .clk(clk), .n_reset(n_reset), .freeze(freeze),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .last_grant(last_grant), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: whose turn it is, last winner, count, and the pending write.
   int m_turn, m_last, m_cnt, m_wen, m_waddr, m_wdata;

   typedef struct {
      bit f; bit v0; int a0; int d0; bit v1; int a1; int d1;
      bit r0; bit r1; bit wen; int waddr; int wdata; int last; int cnt;
   } row_t;
   row_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_turn = 0; m_last = 0; m_cnt = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
   endtask

   // Winner under the round-robin rules: -1 when nobody may be granted.
   function automatic int model_winner(bit f, bit v0, bit v1);
      int cands[$];
      if (!n_reset || f) return -1;
      if (v0) cands.push_back(0);
      if (v1) cands.push_back(1);
      if (cands.size() == 0) return -1;
      if (cands.size() == 1) return cands[0];
      return m_turn;
   endfunction

   task automatic model_clock(input int g, input int addr, input int data);
      if (g < 0) begin
         m_wen = 0;
      end else begin
         m_last = g;
         m_turn = 1 - g;
         m_wen  = (addr != 0) ? 1 : 0;
         if (m_wen == 1) begin
            m_waddr = addr;
            m_wdata = data;
            m_cnt   = (m_cnt + 1) % (1 << W);
         end
      end
   endtask

   task automatic drive(input bit f, input bit v0, input int a0, input int d0,
                        input bit v1, input int a1, input int d1);
      freeze = f;
      req0_valid = v0; req0_addr = A'(a0); req0_data = N'(d0);
      req1_valid = v1; req1_addr = A'(a1); req1_data = N'(d1);
   endtask

   // One clock of traffic checked against the model; entered and left at negedge.
   task automatic model_cycle(input bit f, input bit v0, input int a0, input int d0,
                              input bit v1, input int a1, input int d1, output int g);
      drive(f, v0, a0, d0, v1, a1, d1);
      #1;
      g = model_winner(f, v0, v1);
      chk("rnd_ready0", req0_ready, (g == 0));
      chk("rnd_ready1", req1_ready, (g == 1));
      @(posedge clk);
      model_clock(g, (g == 1) ? a1 : a0, (g == 1) ? d1 : d0);
      @(negedge clk);
      chk("rnd_wr_en", wr_en, m_wen);
      if (m_wen == 1) begin
         chk("rnd_wr_addr", wr_addr, m_waddr);
         chk("rnd_wr_data", wr_data, m_wdata);
      end
      chk("rnd_last_grant", last_grant, m_last);
      chk("rnd_wr_count", wr_count, m_cnt);
   endtask

   // Directed vector: compared against the table's constants, model kept in step.
   task automatic apply_row(input row_t r, input int idx);
      int g;
      drive(r.f, r.v0, r.a0, r.d0, r.v1, r.a1, r.d1);
      #1;
      chk($sformatf("vec%0d_ready0", idx), req0_ready, r.r0);
      chk($sformatf("vec%0d_ready1", idx), req1_ready, r.r1);
      g = model_winner(r.f, r.v0, r.v1);
      @(posedge clk);
      model_clock(g, (g == 1) ? r.a1 : r.a0, (g == 1) ? r.d1 : r.d0);
      @(negedge clk);
      chk($sformatf("vec%0d_wr_en", idx), wr_en, r.wen);
      if (r.wen) begin
         chk($sformatf("vec%0d_wr_addr", idx), wr_addr, r.waddr);
         chk($sformatf("vec%0d_wr_data", idx), wr_data, r.wdata);
      end
      chk($sformatf("vec%0d_last_grant", idx), last_grant, r.last);
      chk($sformatf("vec%0d_wr_count", idx), wr_count, r.cnt);
   endtask

   initial begin
      int g;
      bit v0, v1, f;
      int a0, d0, a1, d1;

      //          f  v0 a0 d0   v1 a1 d1   r0 r1 wen wa wd  last cnt
      tbl[0]  = '{0, 1, 3, 133, 0, 0, 0,   1, 0, 1,  3, 133, 0, 1};
      tbl[1]  = '{0, 0, 0, 0,   0, 0, 0,   0, 0, 0,  0, 0,   0, 1};
      tbl[2]  = '{0, 1, 2, 222, 1, 5, 54,  0, 1, 1,  5, 54,  1, 2};
      tbl[3]  = '{0, 1, 2, 222, 1, 5, 54,  1, 0, 1,  2, 222, 0, 3};
      tbl[4]  = '{0, 1, 2, 222, 1, 5, 54,  0, 1, 1,  5, 54,  1, 4};
      tbl[5]  = '{0, 1, 2, 222, 1, 5, 54,  1, 0, 1,  2, 222, 0, 5};
      tbl[6]  = '{0, 0, 0, 0,   1, 0, 99,  0, 1, 0,  0, 0,   1, 5};
      tbl[7]  = '{0, 1, 2, 222, 1, 5, 54,  1, 0, 1,  2, 222, 0, 6};
      tbl[8]  = '{1, 1, 2, 222, 1, 5, 54,  0, 0, 0,  0, 0,   0, 6};
      tbl[9]  = '{1, 1, 2, 222, 1, 5, 54,  0, 0, 0,  0, 0,   0, 6};
      tbl[10] = '{1, 1, 2, 222, 1, 5, 54,  0, 0, 0,  0, 0,   0, 6};
      tbl[11] = '{0, 1, 2, 222, 1, 5, 54,  0, 1, 1,  5, 54,  1, 7};
      tbl[12] = '{0, 1, 7, 165, 1, 5, 54,  1, 0, 1,  7, 165, 0, 8};
      tbl[13] = '{1, 1, 7, 165, 0, 0, 0,   0, 0, 0,  0, 0,   0, 8};
      tbl[14] = '{0, 0, 0, 0,   0, 0, 0,   0, 0, 0,  0, 0,   0, 8};

      model_reset();

      // Reset held with both sources requesting.
      drive(0, 1, 1, 11, 1, 6, 66);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_last_grant", last_grant, 1'b0);
      n_reset = 1'b1;
      #1;
      chk("rel_ready0", req0_ready, 1'b1);
      chk("rel_ready1", req1_ready, 1'b0);

      for (int i = 0; i < 15; i++) begin
         apply_row(tbl[i], i);
      end

      // Reset arriving while a write is on the port.
      model_cycle(0, 1, 4, 60, 0, 0, 0, g);
      chk("midrst_pre_wr_en", wr_en, 1'b1);
      drive(0, 1, 4, 61, 1, 2, 77);
      n_reset = 1'b0;
      #1;
      chk("midrst_wr_en", wr_en, 1'b0);
      chk("midrst_wr_count", wr_count, 0);
      chk("midrst_ready0", req0_ready, 1'b0);
      chk("midrst_ready1", req1_ready, 1'b0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      n_reset = 1'b1;
      model_cycle(0, 1, 4, 61, 1, 2, 77, g);
      chk("midrst_first_winner", g, 0);

      // Randomized traffic; a source holds its request until granted.
      v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      for (int c = 0; c < 800; c++) begin
         if (!v0) begin
            v0 = ($urandom_range(0, 3) != 0);
            a0 = $urandom_range(0, 7);
            d0 = $urandom_range(0, 255);
         end
         if (!v1) begin
            v1 = ($urandom_range(0, 3) != 0);
            a1 = $urandom_range(0, 7);
            d1 = $urandom_range(0, 255);
         end
         f = ($urandom_range(0, 9) == 0);
         model_cycle(f, v0, a0, d0, v1, a1, d1, g);
         if (g == 0) v0 = 0;
         if (g == 1) v1 = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
